conv2d_stream_core: RTL and testbench
=====================================

// Module: conv2d_stream_core
// PURPOSE
// Streaming KxK 2D convolution on a raster pixel stream (dstream x in, dstream y out).
// Successor to the fixed-kernel convolver. Adds:
//   - true valid/ready backpressure and asynchronous active-low reset
//   - runtime-writable kernel
//   - round-to-nearest with signed saturation, plus a saturation status flag
//   - an end-of-frame marker on the output
// Sits between the pixel source (camera/decoder) and downstream filters or VGA output.
// PARAMETERS
// W        32   signed fixed-point sample and coefficient width
// W_FRAC   16   fractional bits of samples and coefficients (0..W-1)
// WIDTH    320  pixels per line (>= K)
// HEIGHT   240  lines per frame (>= K)
// K        5    kernel size, odd, 3..7
// PORTS
// clk        in   1               system clock, rising edge
// rst_n      in   1               asynchronous active-low reset
// x.data     in   W               signed input pixel, raster order
// x.valid    in   1               input pixel valid
// x.ready    out  1               core accepts a pixel this cycle
// y.data     out  W               signed filtered pixel
// y.valid    out  1               output pixel valid
// y.ready    in   1               downstream accepts output
// coef_we    in   1               kernel coefficient write strobe
// coef_addr  in   $clog2(K*K)     coefficient index, row*K+col, 0 = top-left
// coef_data  in   W               signed coefficient value
// sat_clr    in   1               clears sat_flag
// sat_flag   out  1               sticky: an output was saturated
// y_eof      out  1               high with the last valid output of a frame
// BEHAVIOUR
// - Reset (rst_n low, async):
//     - y.valid=0, y.data=0, y_eof=0, sat_flag=0
//     - col/row counters = 0
//     - kernel = identity: centre coefficient = 1<<W_FRAC, all others 0
//     - Line-buffer RAM is not reset; it is gated by the row counter.
// - Handshake:
//     - x.ready = y.ready | ~y.valid (single output register, no skid).
//     - Accept = x.valid & x.ready. Nothing advances without an accept.
//     - y.data, y.valid and y_eof are held stable while y.valid & ~y.ready.
// - Buffering:
//     - K-1 line buffers of WIDTH samples each, plus a KxK window register.
//     - All shift only on accept.
// - Counters:
//     - col wraps at WIDTH-1, which increments row.
//     - row wraps at HEIGHT-1, returning to (0,0). The next frame starts with no gap.
// - Output rule:
//     - The accept of pixel (row,col) with row>=K-1 and col>=K-1 yields one output on the next cycle.
//     - That output covers the window rows row-K+1..row, cols col-K+1..col.
//     - All other accepts yield no output; y.valid falls if the register was drained.
//     - Outputs per frame: (HEIGHT-K+1)*(WIDTH-K+1). Latency: 1 cycle after accept.
// - Kernel orientation: coef(r,c) multiplies window sample (row-K+1+r, col-K+1+c). This is correlation, not flipped.
// - Arithmetic:
//     - K*K products of 2W bits, summed into an accumulator of 2W+$clog2(K*K)+1 bits.
//     - If W_FRAC>0, add 1<<(W_FRAC-1), then arithmetic shift right by W_FRAC.
//     - Saturate to [-2^(W-1), 2^(W-1)-1]. On saturation, set sat_flag.
// - sat_flag:
//     - Set has priority over sat_clr in the same cycle.
//     - Cleared by sat_clr or rst_n.
// - Coefficient write:
//     - Takes effect for outputs computed from accepts at least 1 cycle after coef_we.
//     - Writes are allowed mid-frame; there is no handshake.
//     - Addresses >= K*K are ignored.
// - y_eof asserts with the output for (HEIGHT-1, WIDTH-1) and follows y.valid holding rules.
// - Reset mid-frame: state returns to (0,0) immediately. The next accepted pixel is treated as pixel (0,0).
// TESTING
// 1. K=3, WIDTH=8, HEIGHT=6, identity kernel, ramp input p=row*8+col, y.ready=1
//      -> 24 outputs; the output for accept (r,c) equals the pixel (r-1,c-1) (centre tap of window); y_eof on the 24th.
// 2. Same config, y.ready toggled with a random 50% pattern
//      -> identical output sequence to test 1; y.data stable while stalled; no loss or duplication.
// 3. W=8, W_FRAC=0, all nine coefs = 1, constant input 100
//      -> every output 127, sat_flag=1; after sat_clr, input 10 -> output 90, sat_flag stays 0.
// 4. W=16, W_FRAC=4, all coefs 0 except centre = 0x0008 (0.5), input 0x0003
//      -> output 0x0002 (rounded up from 0x0001.8).
// 5. Identity kernel; write coef centre=0 and top-left=1<<W_FRAC mid-frame
//      -> subsequent outputs equal window pixel (r-2,c-2).
// 6. Assert rst_n low after 20 accepts, then stream a full frame
//      -> no output until row>=2 & col>=2 of the new frame; output count again 24.

Source files
------------

// File: rtl/conv2d_stream_core.sv
// Streaming KxK 2D correlation over a raster pixel stream with valid/ready
// handshake, runtime-writable kernel, round-to-nearest and signed saturation.
module conv2d_stream_core #(
    parameter int W      = 32,
    parameter int W_FRAC = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int K      = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [W-1:0]    x_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic signed [W-1:0]    y_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    input  logic                   coef_we,
    input  logic [$clog2(K*K)-1:0] coef_addr,
    input  logic signed [W-1:0]    coef_data,
    input  logic                   sat_clr,
    output logic                   sat_flag,
    output logic                   y_eof
);

    localparam int KK     = K * K;
    localparam int AB     = $clog2(KK);
    localparam int AW     = 2 * W + $clog2(KK) + 1;
    localparam int CW     = $clog2(WIDTH);
    localparam int RW     = $clog2(HEIGHT);
    localparam int CENTRE = (K / 2) * K + (K / 2);
    localparam int RSH    = (W_FRAC > 0) ? W_FRAC - 1 : 0;

    localparam logic signed [W-1:0]  COEF_ONE = {{(W-1){1'b0}}, 1'b1} << W_FRAC;
    localparam logic signed [AW-1:0] RND      = (W_FRAC > 0) ? ({{(AW-1){1'b0}}, 1'b1} << RSH) : '0;
    localparam logic signed [AW-1:0] MAXV     = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV     = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          win_full;
    logic          last_pos;

    logic signed [W-1:0] coef     [KK];
    logic signed [W-1:0] line_buf [K-1][WIDTH];
    logic signed [W-1:0] win      [K][K];
    logic signed [W-1:0] win_nxt  [K][K];
    logic signed [W-1:0] column   [K];

    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  rounded;
    logic signed [AW-1:0]  shifted;
    logic                  sat_hi;
    logic                  sat_lo;
    logic signed [W-1:0]   sat_val;

    assign x_ready  = y_ready | ~y_valid;
    assign accept   = x_valid & x_ready;
    assign win_full = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    assign last_pos = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Column entering the window: line_buf[0] holds the previous line, deeper buffers older lines.
    always_comb begin
        column[K-1] = x_data;
        for (int unsigned i = 0; i < K - 1; i++) begin
            column[K-2-i] = line_buf[i][col];
        end
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][K-1] = column[r];
        end
    end

    // Line buffers and window carry no reset; stale contents are never used before row/col gating opens.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[0][col] <= x_data;
            for (int unsigned i = 1; i < K - 1; i++) begin
                line_buf[i][col] <= line_buf[i-1][col];
            end
            win <= win_nxt;
        end
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                prod = $signed({{W{win_nxt[r][c][W-1]}}, win_nxt[r][c]})
                     * $signed({{W{coef[r*K+c][W-1]}}, coef[r*K+c]});
                acc  = acc + $signed({{(AW-2*W){prod[2*W-1]}}, prod});
            end
        end
        rounded = acc + RND;
        shifted = rounded >>> W_FRAC;
        sat_hi  = shifted > MAXV;
        sat_lo  = shifted < MINV;
        if (sat_hi) begin
            sat_val = MAXV[W-1:0];
        end else if (sat_lo) begin
            sat_val = MINV[W-1:0];
        end else begin
            sat_val = shifted[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < KK; i++) begin
                coef[i] <= (i == CENTRE) ? COEF_ONE : '0;
            end
        end else if (coef_we && (coef_addr < AB'(KK))) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid  <= 1'b0;
            y_data   <= '0;
            y_eof    <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (accept) begin
                y_valid <= win_full;
                y_eof   <= win_full & last_pos;
                if (win_full) begin
                    y_data <= sat_val;
                end
            end else if (y_ready) begin
                y_valid <= 1'b0;
                y_eof   <= 1'b0;
            end
            sat_flag <= (accept & win_full & (sat_hi | sat_lo)) | (sat_flag & ~sat_clr);
        end
    end

endmodule

// File: tb/tb_conv2d_stream_core.sv
// Self-checking bench for conv2d_stream_core: frame-level reference model for the
// Q16 instance plus literal checks on small-width saturation and rounding instances.
module tb_conv2d_stream_core;

    localparam int K  = 3;
    localparam int WD = 8;
    localparam int HT = 6;
    localparam int WA = 32;
    localparam int FA = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic rst_n_bc = 1'b0;

    logic signed [WA-1:0] xa_data = '0, ya_data, coef_data_a = '0;
    logic xa_valid = 1'b0, xa_ready, ya_valid, ya_ready = 1'b1, ya_eof, sat_a;
    logic coef_we_a = 1'b0, sat_clr_a = 1'b0;
    logic [3:0] coef_addr_a = '0;

    logic signed [7:0] xb_data = '0, yb_data, coef_data_b = '0;
    logic xb_ready, yb_valid, yb_eof, sat_b, coef_we_b = 1'b0, sat_clr_b = 1'b0;
    logic [3:0] coef_addr_b = '0;

    logic signed [15:0] xc_data = '0, yc_data, coef_data_c = '0;
    logic xc_ready, yc_valid, yc_eof, sat_c, coef_we_c = 1'b0;
    logic [3:0] coef_addr_c = '0;

    logic x_valid_bc = 1'b0;

    conv2d_stream_core #(.W(WA), .W_FRAC(FA), .WIDTH(WD), .HEIGHT(HT), .K(K)) dut_a (
        .clk(clk), .rst_n(rst_n), .x_data(xa_data), .x_valid(xa_valid), .x_ready(xa_ready),
        .y_data(ya_data), .y_valid(ya_valid), .y_ready(ya_ready), .coef_we(coef_we_a),
        .coef_addr(coef_addr_a), .coef_data(coef_data_a), .sat_clr(sat_clr_a),
        .sat_flag(sat_a), .y_eof(ya_eof));

    conv2d_stream_core #(.W(8), .W_FRAC(0), .WIDTH(WD), .HEIGHT(HT), .K(K)) dut_b (
        .clk(clk), .rst_n(rst_n_bc), .x_data(xb_data), .x_valid(x_valid_bc), .x_ready(xb_ready),
        .y_data(yb_data), .y_valid(yb_valid), .y_ready(1'b1), .coef_we(coef_we_b),
        .coef_addr(coef_addr_b), .coef_data(coef_data_b), .sat_clr(sat_clr_b),
        .sat_flag(sat_b), .y_eof(yb_eof));

    conv2d_stream_core #(.W(16), .W_FRAC(4), .WIDTH(WD), .HEIGHT(HT), .K(K)) dut_c (
        .clk(clk), .rst_n(rst_n_bc), .x_data(xc_data), .x_valid(x_valid_bc), .x_ready(xc_ready),
        .y_data(yc_data), .y_valid(yc_valid), .y_ready(1'b1), .coef_we(coef_we_c),
        .coef_addr(coef_addr_c), .coef_data(coef_data_c), .sat_clr(1'b0),
        .sat_flag(sat_c), .y_eof(yc_eof));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model for dut_a: whole-frame image plus kernel, evaluated per output position.
    typedef struct {
        logic signed [WA-1:0] d;
        bit                   eof;
    } exp_t;

    logic signed [WA-1:0] img  [HT][WD];
    logic signed [WA-1:0] kern [K*K];
    exp_t                 q[$];
    logic signed [WA-1:0] out_log[$];
    logic signed [WA-1:0] log1[$];
    int m_row = 0, m_col = 0, eof_cnt = 0, eof_idx = -1;
    bit m_sat = 1'b0;

    function automatic void kern_identity();
        for (int i = 0; i < K * K; i++) kern[i] = (i == (K * K) / 2) ? (32'sd1 <<< FA) : 32'sd0;
    endfunction

    function automatic void model_calc(input int r, input int c,
                                       output logic signed [WA-1:0] res, output bit sat);
        logic signed [127:0] s, mx, mn;
        longint p;
        s = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
                p = longint'(img[r-K+1+i][c-K+1+j]) * longint'(kern[i*K+j]);
                s = s + p;
            end
        if (FA > 0) s = s + (128'sd1 <<< (FA - 1));
        s  = s >>> FA;
        mx = (128'sd1 <<< (WA - 1)) - 1;
        mn = -(128'sd1 <<< (WA - 1));
        sat = (s > mx) || (s < mn);
        if (s > mx)      res = mx[WA-1:0];
        else if (s < mn) res = mn[WA-1:0];
        else             res = s[WA-1:0];
    endfunction

    initial begin : compare_a
        bit prev_stall;
        bit sat_set;
        bit msat;
        logic signed [WA-1:0] prev_d, mres;
        bit prev_e;
        exp_t e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_e = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                q.delete();
                m_row = 0;
                m_col = 0;
                m_sat = 1'b0;
                prev_stall = 1'b0;
                kern_identity();
            end else begin
                check("a_valid", ya_valid, q.size() != 0);
                check("a_sat_flag", sat_a, m_sat);
                if (prev_stall) begin
                    check("a_hold_data", ya_data, prev_d);
                    check("a_hold_eof", ya_eof, prev_e);
                end
                if (ya_valid && ya_ready && q.size() != 0) begin
                    e = q.pop_front();
                    check("a_data", ya_data, e.d);
                    check("a_eof", ya_eof, e.eof);
                    out_log.push_back(ya_data);
                    if (ya_eof) begin
                        eof_cnt++;
                        eof_idx = out_log.size() - 1;
                    end
                end
                prev_stall = ya_valid && !ya_ready;
                prev_d = ya_data;
                prev_e = ya_eof;
                sat_set = 1'b0;
                if (xa_valid && xa_ready) begin
                    img[m_row][m_col] = xa_data;
                    if (m_row >= K - 1 && m_col >= K - 1) begin
                        model_calc(m_row, m_col, mres, msat);
                        q.push_back('{mres, (m_row == HT - 1) && (m_col == WD - 1)});
                        sat_set = msat;
                    end
                    m_col++;
                    if (m_col == WD) begin
                        m_col = 0;
                        m_row++;
                        if (m_row == HT) m_row = 0;
                    end
                end
                m_sat = sat_set | (m_sat & !sat_clr_a);
                if (coef_we_a && coef_addr_a < K * K) kern[coef_addr_a] = coef_data_a;
            end
        end
    end

    task automatic send_pix(input logic signed [WA-1:0] v, input bit stall);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        xa_valid = 1'b1;
        xa_data = v;
        while (!done) begin
            ya_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            done = xa_ready;
            @(negedge clk);
            n++;
            if (!done && n > 1000) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=%0d required=accept", n);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_ramp(input int start, input int n, input bit stall);
        @(negedge clk);
        for (int i = 0; i < n; i++) send_pix(WA'(((start + i) % (WD * HT)) * 65536), stall);
        xa_valid = 1'b0;
    endtask

    task automatic drain();
        ya_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
    endtask

    task automatic write_coef_a(input int addr, input logic signed [WA-1:0] val);
        @(negedge clk);
        coef_we_a = 1'b1;
        coef_addr_a = 4'(addr);
        coef_data_a = val;
        @(negedge clk);
        coef_we_a = 1'b0;
    endtask

    task automatic run_a();
        int mism;
        // identity kernel, ramp, free-running output
        out_log.delete();
        eof_cnt = 0;
        send_ramp(0, 48, 1'b0);
        drain();
        check("t1_count", out_log.size(), 24);
        check("t1_first", out_log[0], 589824);
        check("t1_last", out_log[23], 2490368);
        check("t1_eof_cnt", eof_cnt, 1);
        check("t1_eof_idx", eof_idx, 23);
        log1 = out_log;
        // random backpressure
        out_log.delete();
        eof_cnt = 0;
        send_ramp(0, 48, 1'b1);
        drain();
        check("t2_count", out_log.size(), 24);
        mism = 0;
        for (int i = 0; i < out_log.size() && i < log1.size(); i++)
            if (out_log[i] != log1[i]) mism++;
        check("t2_same_seq", mism, 0);
        check("t2_eof_cnt", eof_cnt, 1);
        // mid-frame kernel change, plus an out-of-range address that must be ignored
        out_log.delete();
        send_ramp(0, 24, 1'b0);
        write_coef_a(4, 32'sd0);
        write_coef_a(0, 32'sd65536);
        write_coef_a(12, 32'sd12345);
        send_ramp(24, 24, 1'b0);
        drain();
        check("t5_count", out_log.size(), 24);
        check("t5_before", out_log[5], 917504);
        check("t5_after", out_log[6], 524288);
        check("t5_last", out_log[23], 1900544);
        // reset mid-frame with an output pending
        send_ramp(0, 20, 1'b0);
        #1;
        check("t6_pending", ya_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", ya_valid, 0);
        check("t6_rst_data", ya_data, 0);
        check("t6_rst_eof", ya_eof, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_log.delete();
        eof_cnt = 0;
        send_ramp(0, 48, 1'b0);
        drain();
        check("t6_count", out_log.size(), 24);
        check("t6_first", out_log[0], 589824);
        check("t6_last", out_log[23], 2490368);
        check("t6_eof_cnt", eof_cnt, 1);
    endtask

    logic signed [7:0] exp_b = 8'sd127;
    int cnt_b = 0, cnt_c = 0, eof_b = 0;

    initial begin : compare_bc
        forever begin
            @(negedge clk);
            #2;
            if (rst_n_bc) begin
                if (yb_valid) begin
                    cnt_b++;
                    check("b_data", yb_data, exp_b);
                    check("b_eof", yb_eof, (cnt_b % 24) == 0);
                    if (yb_eof) eof_b++;
                end
                if (yc_valid) begin
                    cnt_c++;
                    check("c_data", yc_data, 2);
                end
            end
        end
    end

    task automatic run_bc();
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            coef_we_b = 1'b1;
            coef_addr_b = 4'(i);
            coef_data_b = 8'sd1;
            coef_we_c = (i == 0);
            coef_addr_c = 4'd4;
            coef_data_c = 16'sd8;
            @(negedge clk);
        end
        coef_we_b = 1'b0;
        coef_we_c = 1'b0;
        xb_data = 8'sd100;
        xc_data = 16'sd3;
        x_valid_bc = 1'b1;
        repeat (48) @(negedge clk);
        x_valid_bc = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("b_count1", cnt_b, 24);
        check("c_count", cnt_c, 24);
        check("b_sat_set", sat_b, 1);
        check("c_sat_clear", sat_c, 0);
        @(negedge clk);
        sat_clr_b = 1'b1;
        @(negedge clk);
        sat_clr_b = 1'b0;
        #3;
        check("b_sat_clr", sat_b, 0);
        @(negedge clk);
        exp_b = 8'sd90;
        xb_data = 8'sd10;
        x_valid_bc = 1'b1;
        repeat (48) @(negedge clk);
        x_valid_bc = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("b_count2", cnt_b, 48);
        check("b_sat_stays", sat_b, 0);
        check("b_eof_cnt", eof_b, 2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_valid", ya_valid, 0);
        check("rst_a_data", ya_data, 0);
        check("rst_a_eof", ya_eof, 0);
        check("rst_a_sat", sat_a, 0);
        check("rst_a_ready", xa_ready, 1);
        check("rst_b_valid", yb_valid, 0);
        check("rst_c_valid", yc_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rst_n_bc = 1'b1;
        fork
            run_a();
            run_bc();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
